// File: rtl/z80_bus_bridge_if.sv
// z80_bus_bridge_if
// Memory and I/O request/acknowledge ports of the Z80 bus bridge.
// The bridge drives requests through the master modport; the memory and
// I/O subsystems answer through the slave modport.
interface z80_bus_bridge_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    logic        io_req;
    logic        io_we;
    logic [7:0]  io_addr;
    logic [7:0]  io_wdata;
    logic [7:0]  io_rdata;
    logic        io_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output io_req, io_we, io_addr, io_wdata,
        input  io_rdata, io_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  io_req, io_we, io_addr, io_wdata,
        output io_rdata, io_ack
    );
endinterface

// File: rtl/z80_bus_bridge.sv
// z80_bus_bridge
// Turns the registered strobes of a cen-gated Z80 core into level req/ack
// transactions on separate memory and I/O ports. wait_n is held low from the
// clk after a cycle starts until the transaction has been acknowledged and
// the minimum number of wait states (cen ticks) has elapsed. Read data or the
// IM2 vector is returned on di and held until the next read or INTA.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   - a pending req is abandoned after TIMEOUT_CYC clk, bus_tmo
//               pulses and a read returns 8'hFF.
//   undefined - no timeout; bus_tmo is tied low and a missing ack stalls.
module z80_bus_bridge #(
    parameter int unsigned MEM_WS      = 1,
    parameter int unsigned IO_WS       = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cen,
    input  logic             m1_n,
    input  logic             mreq_n,
    input  logic             iorq_n,
    input  logic             rd_n,
    input  logic             wr_n,
    input  logic [15:0]      A,
    input  logic [7:0]       dout,
    output logic [7:0]       di,
    output logic             wait_n,
    input  logic [7:0]       int_vec,
    output logic             bus_tmo,
    z80_bus_bridge_if.master bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] MEM    = 3'd1;
    localparam logic [2:0] IO     = 3'd2;
    localparam logic [2:0] INTA   = 3'd3;
    localparam logic [2:0] WAITWS = 3'd4;
    localparam logic [2:0] HOLD   = 3'd5;

    localparam logic [3:0]  MEM_WS_L = 4'(MEM_WS);
    localparam logic [3:0]  IO_WS_L  = 4'(IO_WS);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [2:0] state;
    logic [3:0] ws_cnt;
    logic       is_io;
    logic       is_rd;

    logic       start_mem;
    logic       start_io;
    logic       start_inta;
    logic       cpu_idle;
    logic [3:0] ws_min;
    logic       ws_done;
    logic       in_xfer;
    logic       xfer_ack;
    logic       tmo_fire;

    // Bus cycle decode from the raw CPU strobes. A refresh cycle (mreq_n low
    // with neither rd_n nor wr_n) matches none of these and is ignored.
    assign start_mem  = !mreq_n && (!rd_n || !wr_n);
    assign start_io   = !iorq_n && m1_n && (!rd_n || !wr_n);
    assign start_inta = !iorq_n && !m1_n;

    // The CPU has left the bus cycle that was just served; until then the
    // bridge must not re-arm or the same cycle would be issued twice.
    assign cpu_idle = rd_n && wr_n && (iorq_n || m1_n);

    // INTA shares the memory wait-state minimum.
    assign ws_min  = is_io ? IO_WS_L : MEM_WS_L;
    assign ws_done = (ws_cnt >= ws_min);

    assign in_xfer  = (state == MEM) || (state == IO);
    assign xfer_ack = ((state == MEM) && bus.mem_ack) || ((state == IO) && bus.io_ack);

`ifdef BUS_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Count clk cycles while a request is outstanding; cleared outside transfers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_cnt <= 16'd0;
        end else if (in_xfer) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end else begin
            tmo_cnt <= 16'd0;
        end
    end

    // A real ack in the same clk as the limit wins over the timeout.
    assign tmo_fire = in_xfer && !xfer_ack && (tmo_cnt == TMO_LAST);

    // One-clk timeout pulse, aligned with the clk on which req drops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus_tmo <= 1'b0;
        end else begin
            bus_tmo <= tmo_fire;
        end
    end
`else
    logic unused_tmo;

    assign tmo_fire   = 1'b0;
    assign bus_tmo    = 1'b0;
    assign unused_tmo = ^TMO_LAST;
`endif

    // Wait-state counter: cen ticks since entry into MEM/IO/INTA, saturating at 15.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ws_cnt <= 4'd0;
        end else if (state == IDLE) begin
            ws_cnt <= 4'd0;
        end else if ((state != HOLD) && cen && (ws_cnt != 4'hF)) begin
            ws_cnt <= ws_cnt + 4'd1;
        end
    end

    // Main bus-cycle sequencer: issue, await ack, stretch wait_n, then hold off re-issue.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            di            <= 8'hFF;
            wait_n        <= 1'b1;
            is_io         <= 1'b0;
            is_rd         <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 16'd0;
            bus.mem_wdata <= 8'd0;
            bus.io_req    <= 1'b0;
            bus.io_we     <= 1'b0;
            bus.io_addr   <= 8'd0;
            bus.io_wdata  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    // Write wins when rd_n and wr_n are both low.
                    if (start_mem) begin
                        state         <= MEM;
                        wait_n        <= 1'b0;
                        is_io         <= 1'b0;
                        is_rd         <= wr_n;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= !wr_n;
                        bus.mem_addr  <= A;
                        bus.mem_wdata <= dout;
                    end else if (start_io) begin
                        state        <= IO;
                        wait_n       <= 1'b0;
                        is_io        <= 1'b1;
                        is_rd        <= wr_n;
                        bus.io_req   <= 1'b1;
                        bus.io_we    <= !wr_n;
                        bus.io_addr  <= A[7:0];
                        bus.io_wdata <= dout;
                    end else if (start_inta) begin
                        state  <= INTA;
                        wait_n <= 1'b0;
                        is_io  <= 1'b0;
                        is_rd  <= 1'b0;
                        di     <= int_vec;
                    end
                end

                // When the wait-state minimum is already met at ack time the
                // release happens right away, so MEM_WS=0 gives zero waits.
                MEM: begin
                    if (bus.mem_ack || tmo_fire) begin
                        bus.mem_req <= 1'b0;
                        if (is_rd) begin
                            di <= bus.mem_ack ? bus.mem_rdata : 8'hFF;
                        end
                        if (ws_done) begin
                            wait_n <= 1'b1;
                            state  <= HOLD;
                        end else begin
                            state <= WAITWS;
                        end
                    end
                end

                IO: begin
                    if (bus.io_ack || tmo_fire) begin
                        bus.io_req <= 1'b0;
                        if (is_rd) begin
                            di <= bus.io_ack ? bus.io_rdata : 8'hFF;
                        end
                        if (ws_done) begin
                            wait_n <= 1'b1;
                            state  <= HOLD;
                        end else begin
                            state <= WAITWS;
                        end
                    end
                end

                INTA: begin
                    state <= WAITWS;
                end

                WAITWS: begin
                    if (ws_done) begin
                        wait_n <= 1'b1;
                        state  <= HOLD;
                    end
                end

                HOLD: begin
                    if (cpu_idle) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    wait_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// tb_z80_bus_bridge
// Directed bench for z80_bus_bridge: reset values, memory write/read, I/O
// read, INTA, wrong-port and idle acks, refresh, missing ack (stall or
// timeout when BUS_TIMEOUT_EN is defined) and reset during a transaction.
module tb_z80_bus_bridge;

    localparam int MEM_WS = 1;
    localparam int IO_WS  = 2;
    localparam int TMO    = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cen;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n;
    logic [15:0] A;
    logic [7:0]  dout;
    logic [7:0]  di;
    logic        wait_n;
    logic [7:0]  int_vec;
    logic        bus_tmo;

    int checks   = 0;
    int failures = 0;

    int mem_rises = 0;
    int io_rises  = 0;
    int ws_ticks  = 0;
    int mem_cyc   = 0;
    logic mem_req_q = 1'b0;
    logic io_req_q  = 1'b0;

    z80_bus_bridge_if bus_if ();

    z80_bus_bridge #(
        .MEM_WS(MEM_WS),
        .IO_WS(IO_WS),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cen(cen),
        .m1_n(m1_n),
        .mreq_n(mreq_n),
        .iorq_n(iorq_n),
        .rd_n(rd_n),
        .wr_n(wr_n),
        .A(A),
        .dout(dout),
        .di(di),
        .wait_n(wait_n),
        .int_vec(int_vec),
        .bus_tmo(bus_tmo),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    // cen toggles every clk, so it is high one clk and low the next.
    initial begin
        cen = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cen = ~cen;
        end
    end

    // Free-running observation counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_if.mem_req && !mem_req_q) mem_rises++;
        if (bus_if.io_req && !io_req_q) io_rises++;
        if (cen && !wait_n) ws_ticks++;
        if (bus_if.mem_req) mem_cyc++;
        mem_req_q = bus_if.mem_req;
        io_req_q  = bus_if.io_req;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobes(input logic mreq, input logic iorq, input logic m1,
                           input logic rd, input logic wr);
        mreq_n = mreq;
        iorq_n = iorq;
        m1_n   = m1;
        rd_n   = rd;
        wr_n   = wr;
    endtask

    task automatic wait_release(input int max, output int cyc);
        cyc = 0;
        while (!wait_n && cyc < max) begin
            tick(1);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        strobes(1, 1, 1, 1, 1);
        tick(3);
        checks++; if (di !== 8'hFF) begin failures++; $display("FAIL reset_di: got %h expected ff", di); end
        checks++; if (wait_n !== 1'b1) begin failures++; $display("FAIL reset_wait_n: got %b expected 1", wait_n); end
        checks++; if (bus_if.mem_req !== 1'b0 || bus_if.io_req !== 1'b0) begin failures++; $display("FAIL reset_req: got mem=%b io=%b expected 0 0", bus_if.mem_req, bus_if.io_req); end
        checks++; if (bus_if.mem_we !== 1'b0 || bus_if.io_we !== 1'b0) begin failures++; $display("FAIL reset_we: got mem=%b io=%b expected 0 0", bus_if.mem_we, bus_if.io_we); end
        checks++; if (bus_if.mem_addr !== 16'h0 || bus_if.mem_wdata !== 8'h0 || bus_if.io_addr !== 8'h0 || bus_if.io_wdata !== 8'h0) begin failures++; $display("FAIL reset_addr_data: got %h %h %h %h expected zeros", bus_if.mem_addr, bus_if.mem_wdata, bus_if.io_addr, bus_if.io_wdata); end
        checks++; if (bus_tmo !== 1'b0) begin failures++; $display("FAIL reset_bus_tmo: got %b expected 0", bus_tmo); end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_mem_write;
        int cyc;
        A = 16'hC000;
        dout = 8'hA5;
        strobes(0, 1, 1, 1, 0);
        tick(1);
        checks++; if (wait_n !== 1'b0 || bus_if.mem_req !== 1'b1) begin failures++; $display("FAIL wr_start: got wait_n=%b req=%b expected 0 1", wait_n, bus_if.mem_req); end
        checks++; if (bus_if.mem_we !== 1'b1 || bus_if.mem_addr !== 16'hC000 || bus_if.mem_wdata !== 8'hA5) begin failures++; $display("FAIL wr_latch: got we=%b addr=%h wdata=%h expected 1 c000 a5", bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata); end
        bus_if.mem_ack = 1'b1;
        bus_if.mem_rdata = 8'h77;
        tick(1);
        bus_if.mem_ack = 1'b0;
        bus_if.mem_rdata = 8'h00;
        wait_release(20, cyc);
        checks++; if (cyc >= 20) begin failures++; $display("FAIL wr_release: wait_n still %b after %0d clk, required 1", wait_n, cyc); end
        checks++; if (di !== 8'hFF) begin failures++; $display("FAIL wr_di_unchanged: got %h expected ff", di); end
        strobes(1, 1, 1, 1, 1);
        tick(2);
    endtask

    task automatic test_mem_read;
        int r0, c0, t0, cyc;
        r0 = mem_rises; c0 = mem_cyc; t0 = ws_ticks;
        A = 16'h1234;
        strobes(0, 1, 0, 0, 1);
        tick(1);
        checks++; if (wait_n !== 1'b0 || bus_if.mem_req !== 1'b1) begin failures++; $display("FAIL rd_latency: got wait_n=%b req=%b expected 0 1", wait_n, bus_if.mem_req); end
        checks++; if (bus_if.mem_we !== 1'b0 || bus_if.mem_addr !== 16'h1234) begin failures++; $display("FAIL rd_latch: got we=%b addr=%h expected 0 1234", bus_if.mem_we, bus_if.mem_addr); end
        tick(3);
        bus_if.mem_ack = 1'b1;
        bus_if.mem_rdata = 8'h5A;
        tick(1);
        bus_if.mem_ack = 1'b0;
        bus_if.mem_rdata = 8'h00;
        checks++; if (di !== 8'h5A) begin failures++; $display("FAIL rd_di: got %h expected 5a", di); end
        checks++; if (bus_if.mem_req !== 1'b0) begin failures++; $display("FAIL rd_req_drop: got %b expected 0", bus_if.mem_req); end
        checks++; if (mem_cyc - c0 !== 4) begin failures++; $display("FAIL rd_req_len: got %0d clk expected 4", mem_cyc - c0); end
        wait_release(20, cyc);
        checks++; if (cyc >= 20) begin failures++; $display("FAIL rd_release: wait_n still %b after %0d clk, required 1", wait_n, cyc); end
        checks++; if (ws_ticks - t0 < MEM_WS) begin failures++; $display("FAIL rd_ws: got %0d cen ticks expected >= %0d", ws_ticks - t0, MEM_WS); end
        // CPU keeps the strobes active for a while after wait_n rises.
        tick(3);
        strobes(1, 1, 1, 1, 1);
        tick(2);
        checks++; if (mem_rises - r0 !== 1) begin failures++; $display("FAIL rd_single_req: got %0d requests expected 1", mem_rises - r0); end
    endtask

    task automatic test_io_read;
        int r0, m0, t0, cyc;
        r0 = io_rises; m0 = mem_rises; t0 = ws_ticks;
        A = 16'hAB7F;
        strobes(1, 0, 1, 0, 1);
        tick(1);
        checks++; if (bus_if.io_req !== 1'b1 || bus_if.io_addr !== 8'h7F || bus_if.io_we !== 1'b0) begin failures++; $display("FAIL io_start: got req=%b addr=%h we=%b expected 1 7f 0", bus_if.io_req, bus_if.io_addr, bus_if.io_we); end
        bus_if.io_ack = 1'b1;
        bus_if.io_rdata = 8'h3C;
        tick(1);
        bus_if.io_ack = 1'b0;
        bus_if.io_rdata = 8'h00;
        checks++; if (di !== 8'h3C || bus_if.io_req !== 1'b0) begin failures++; $display("FAIL io_di: got di=%h req=%b expected 3c 0", di, bus_if.io_req); end
        wait_release(20, cyc);
        checks++; if (cyc >= 20) begin failures++; $display("FAIL io_release: wait_n still %b after %0d clk, required 1", wait_n, cyc); end
        checks++; if (ws_ticks - t0 < IO_WS) begin failures++; $display("FAIL io_ws: got %0d cen ticks expected >= %0d", ws_ticks - t0, IO_WS); end
        tick(2);
        strobes(1, 1, 1, 1, 1);
        tick(2);
        checks++; if (io_rises - r0 !== 1 || mem_rises - m0 !== 0) begin failures++; $display("FAIL io_single_req: got io=%0d mem=%0d expected 1 0", io_rises - r0, mem_rises - m0); end
    endtask

    task automatic test_inta;
        int r0, m0, t0, cyc;
        r0 = io_rises; m0 = mem_rises; t0 = ws_ticks;
        int_vec = 8'hE8;
        strobes(1, 0, 0, 1, 1);
        tick(1);
        checks++; if (wait_n !== 1'b0 || di !== 8'hE8) begin failures++; $display("FAIL inta_start: got wait_n=%b di=%h expected 0 e8", wait_n, di); end
        wait_release(20, cyc);
        checks++; if (cyc >= 20) begin failures++; $display("FAIL inta_release: wait_n still %b after %0d clk, required 1", wait_n, cyc); end
        checks++; if (ws_ticks - t0 < MEM_WS) begin failures++; $display("FAIL inta_ws: got %0d cen ticks expected >= %0d", ws_ticks - t0, MEM_WS); end
        tick(2);
        strobes(1, 1, 1, 1, 1);
        tick(2);
        checks++; if (io_rises - r0 !== 0 || mem_rises - m0 !== 0) begin failures++; $display("FAIL inta_no_req: got io=%0d mem=%0d expected 0 0", io_rises - r0, mem_rises - m0); end
    endtask

    task automatic test_stray_ack;
        int cyc;
        // Ack while idle must not disturb di or wait_n.
        bus_if.mem_ack = 1'b1;
        bus_if.mem_rdata = 8'h11;
        bus_if.io_ack = 1'b1;
        bus_if.io_rdata = 8'h22;
        tick(1);
        bus_if.mem_ack = 1'b0;
        bus_if.io_ack = 1'b0;
        tick(1);
        checks++; if (di !== 8'hE8 || wait_n !== 1'b1) begin failures++; $display("FAIL idle_ack: got di=%h wait_n=%b expected e8 1", di, wait_n); end
        // Ack on the I/O port during a memory read is ignored.
        A = 16'h0042;
        strobes(0, 1, 1, 0, 1);
        tick(1);
        bus_if.io_ack = 1'b1;
        bus_if.io_rdata = 8'h99;
        tick(1);
        bus_if.io_ack = 1'b0;
        tick(1);
        checks++; if (bus_if.mem_req !== 1'b1 || wait_n !== 1'b0 || di !== 8'hE8) begin failures++; $display("FAIL wrong_port_ack: got req=%b wait_n=%b di=%h expected 1 0 e8", bus_if.mem_req, wait_n, di); end
        bus_if.mem_ack = 1'b1;
        bus_if.mem_rdata = 8'hC3;
        tick(1);
        bus_if.mem_ack = 1'b0;
        wait_release(20, cyc);
        checks++; if (di !== 8'hC3 || cyc >= 20) begin failures++; $display("FAIL right_port_ack: got di=%h wait_n=%b expected c3 1", di, wait_n); end
        strobes(1, 1, 1, 1, 1);
        tick(2);
    endtask

    task automatic test_refresh;
        int m0;
        m0 = mem_rises;
        A = 16'h0077;
        strobes(0, 1, 1, 1, 1);
        tick(3);
        checks++; if (wait_n !== 1'b1 || mem_rises - m0 !== 0) begin failures++; $display("FAIL refresh: got wait_n=%b reqs=%0d expected 1 0", wait_n, mem_rises - m0); end
        strobes(1, 1, 1, 1, 1);
        tick(2);
    endtask

    task automatic test_missing_ack;
`ifdef BUS_TIMEOUT_EN
        int k, cyc;
        A = 16'h2000;
        strobes(0, 1, 1, 0, 1);
        tick(1);
        k = 0;
        while (!bus_tmo && k < 20) begin
            tick(1);
            k++;
        end
        checks++; if (k !== TMO) begin failures++; $display("FAIL tmo_time: got pulse after %0d clk expected %0d", k, TMO); end
        checks++; if (di !== 8'hFF || bus_if.mem_req !== 1'b0) begin failures++; $display("FAIL tmo_result: got di=%h req=%b expected ff 0", di, bus_if.mem_req); end
        wait_release(20, cyc);
        checks++; if (cyc >= 20) begin failures++; $display("FAIL tmo_release: wait_n still %b, required 1", wait_n); end
        tick(1);
        checks++; if (bus_tmo !== 1'b0) begin failures++; $display("FAIL tmo_pulse_len: got %b expected 0", bus_tmo); end
        strobes(1, 1, 1, 1, 1);
        tick(2);
`else
        A = 16'h2000;
        strobes(0, 1, 1, 0, 1);
        tick(30);
        checks++; if (wait_n !== 1'b0 || bus_if.mem_req !== 1'b1) begin failures++; $display("FAIL stall: got wait_n=%b req=%b expected 0 1", wait_n, bus_if.mem_req); end
        checks++; if (bus_tmo !== 1'b0) begin failures++; $display("FAIL stall_tmo: got %b expected 0", bus_tmo); end
        strobes(1, 1, 1, 1, 1);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
`endif
    endtask

    task automatic test_reset_mid;
        A = 16'h4000;
        strobes(0, 1, 1, 0, 1);
        tick(1);
        checks++; if (bus_if.mem_req !== 1'b1) begin failures++; $display("FAIL rst_mid_pending: got %b expected 1", bus_if.mem_req); end
        reset_n = 1'b0;
        strobes(1, 1, 1, 1, 1);
        tick(1);
        checks++; if (bus_if.mem_req !== 1'b0 || wait_n !== 1'b1) begin failures++; $display("FAIL rst_mid_drop: got req=%b wait_n=%b expected 0 1", bus_if.mem_req, wait_n); end
        reset_n = 1'b1;
        bus_if.mem_ack = 1'b1;
        bus_if.mem_rdata = 8'h66;
        tick(1);
        bus_if.mem_ack = 1'b0;
        tick(2);
        checks++; if (di !== 8'hFF || bus_if.mem_req !== 1'b0 || wait_n !== 1'b1) begin failures++; $display("FAIL rst_late_ack: got di=%h req=%b wait_n=%b expected ff 0 1", di, bus_if.mem_req, wait_n); end
    endtask

    initial begin
        reset_n = 1'b0;
        strobes(1, 1, 1, 1, 1);
        A = 16'h0;
        dout = 8'h0;
        int_vec = 8'h0;
        bus_if.mem_ack = 1'b0;
        bus_if.mem_rdata = 8'h0;
        bus_if.io_ack = 1'b0;
        bus_if.io_rdata = 8'h0;
        test_reset();
        test_mem_write();
        test_mem_read();
        test_io_read();
        test_inta();
        test_stray_ack();
        test_refresh();
        test_missing_ack();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
